// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: register/data widths,
// the queue entry record, the grant encoding and a register one-hot helper.
package wb_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned NREG   = 8;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // One pending register-file write ("reg" is a keyword, hence dst_reg)
  typedef struct packed {
    reg_idx_t dst_reg;
    data_t    data;
  } wb_entry_t;

  // Which queue head (if any) is written this cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_e;

  function automatic logic [NREG-1:0] reg_onehot(input reg_idx_t r);
    logic [NREG-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the write-back stage source handshakes and register-file outputs.
// master: the producer side (execute units / bench); slave: the stage itself.
interface wb_stage_if;
  import wb_pkg::*;

  logic                  iALU_VALID;
  logic [REG_W-1:0]      iALU_REG;
  logic [DATA_W-1:0]     iALU_DATA;
  logic                  oALU_READY;

  logic                  iMEM_VALID;
  logic [REG_W-1:0]      iMEM_REG;
  logic [DATA_W-1:0]     iMEM_DATA;
  logic                  oMEM_READY;

  logic                  oWR_EN;
  logic [REG_W-1:0]      oWRREG;
  logic [DATA_W-1:0]     oDATA;
  logic [NREG-1:0]       oBUSY;

  modport master (
    output iALU_VALID, iALU_REG, iALU_DATA,
    input  oALU_READY,
    output iMEM_VALID, iMEM_REG, iMEM_DATA,
    input  oMEM_READY,
    input  oWR_EN, oWRREG, oDATA, oBUSY
  );

  modport slave (
    input  iALU_VALID, iALU_REG, iALU_DATA,
    output oALU_READY,
    input  iMEM_VALID, iMEM_REG, iMEM_DATA,
    output oMEM_READY,
    output oWR_EN, oWRREG, oDATA, oBUSY
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for one write-back source. READY is a registered
// "not full" so it never depends on same-cycle push or pop; every slot's
// content and occupancy is exposed for the busy scoreboard.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output logic                        ready,
  output logic                        full,
  output logic                        empty,
  output wb_entry_t                   head,
  output wb_entry_t [DEPTH-1:0]       entries,
  output logic      [DEPTH-1:0]       entry_valid
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q,  count_d;
  logic                  ready_q,  ready_d;
  wb_entry_t [DEPTH-1:0] mem_q,    mem_d;
  logic                  push_acc, pop_acc;

  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign ready       = ready_q;
  assign head        = mem_q[rd_ptr_q];
  assign entries     = mem_q;
  // ready_q is low whenever the queue was full at the start of the cycle,
  // so a same-cycle pop never frees room for a push
  assign push_acc    = push & ready_q & ~full;
  assign pop_acc     = pop & ~empty;

  // Next pointer, count, storage and registered ready
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
    ready_d = (count_d != (AW+1)'(DEPTH));
  end

  // Slot occupancy: slot i is live when its distance from the read pointer is below the count
  always_comb begin
    logic [AW-1:0] offs;
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs           = AW'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, offs} < count_q);
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage; contents are only observed through occupancy so no reset is needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: two source queues (ALU results, load data) merged onto a
// single register-file write port. MEM has priority except when the ALU has
// waited STARVE_MAX consecutive MEM grants. Define WB_BUSY_EN to build the
// per-register pending-write scoreboard on oBUSY; otherwise oBUSY reads 0.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iALU_VALID,
  input  logic [REG_W-1:0]  iALU_REG,
  input  logic [DATA_W-1:0] iALU_DATA,
  output logic              oALU_READY,
  input  logic              iMEM_VALID,
  input  logic [REG_W-1:0]  iMEM_REG,
  input  logic [DATA_W-1:0] iMEM_DATA,
  output logic              oMEM_READY,
  output logic              oWR_EN,
  output logic [REG_W-1:0]  oWRREG,
  output logic [DATA_W-1:0] oDATA,
  output logic [NREG-1:0]   oBUSY
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 2);

  wb_entry_t             alu_in, mem_in;
  wb_entry_t             alu_head, mem_head;
  wb_entry_t [DEPTH-1:0] alu_entries, mem_entries;
  logic      [DEPTH-1:0] alu_vld, mem_vld;
  logic                  alu_full, mem_full;
  logic                  alu_empty, mem_empty;
  logic                  alu_pop, mem_pop;
  gnt_e                  gnt;

  logic [SW-1:0]         starve_q, starve_d;
  logic                  wr_en_q,  wr_en_d;
  reg_idx_t              wrreg_q,  wrreg_d;
  data_t                 data_q,   data_d;

  assign alu_in = '{dst_reg: iALU_REG, data: iALU_DATA};
  assign mem_in = '{dst_reg: iMEM_REG, data: iMEM_DATA};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
    .clk         (iCLK),
    .rst         (iRST),
    .push        (iALU_VALID),
    .push_entry  (alu_in),
    .pop         (alu_pop),
    .ready       (oALU_READY),
    .full        (alu_full),
    .empty       (alu_empty),
    .head        (alu_head),
    .entries     (alu_entries),
    .entry_valid (alu_vld)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_q (
    .clk         (iCLK),
    .rst         (iRST),
    .push        (iMEM_VALID),
    .push_entry  (mem_in),
    .pop         (mem_pop),
    .ready       (oMEM_READY),
    .full        (mem_full),
    .empty       (mem_empty),
    .head        (mem_head),
    .entries     (mem_entries),
    .entry_valid (mem_vld)
  );

  // Arbitration: MEM first unless the waiting ALU has hit its starvation limit
  always_comb begin
    gnt = GNT_NONE;
    if (!mem_empty && !(!alu_empty && (starve_q == SW'(STARVE_MAX)))) begin
      gnt = GNT_MEM;
    end else if (!alu_empty) begin
      gnt = GNT_ALU;
    end
  end

  assign alu_pop = (gnt == GNT_ALU);
  assign mem_pop = (gnt == GNT_MEM);

  // Next write-port contents and starvation count
  always_comb begin
    wr_en_d  = 1'b0;
    wrreg_d  = wrreg_q;
    data_d   = data_q;
    starve_d = starve_q;
    unique case (gnt)
      GNT_ALU: begin
        wr_en_d = 1'b1;
        wrreg_d = alu_head.dst_reg;
        data_d  = alu_head.data;
      end
      GNT_MEM: begin
        wr_en_d = 1'b1;
        wrreg_d = mem_head.dst_reg;
        data_d  = mem_head.data;
      end
      default: ;
    endcase
    if (alu_empty || (gnt == GNT_ALU)) begin
      starve_d = '0;
    end else if (gnt == GNT_MEM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Write-port and starvation registers with synchronous reset
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_en_q  <= 1'b0;
      wrreg_q  <= '0;
      data_q   <= '0;
      starve_q <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      wrreg_q  <= wrreg_d;
      data_q   <= data_d;
      starve_q <= starve_d;
    end
  end

  assign oWR_EN = wr_en_q;
  assign oWRREG = wrreg_q;
  assign oDATA  = data_q;

`ifdef WB_BUSY_EN
  logic [NREG-1:0] busy;

  // Pending-write flags: every live queue slot plus the write being strobed now
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alu_vld[i]) busy = busy | reg_onehot(alu_entries[i].dst_reg);
      if (mem_vld[i]) busy = busy | reg_onehot(mem_entries[i].dst_reg);
    end
    if (wr_en_q) busy = busy | reg_onehot(wrreg_q);
  end

  assign oBUSY = busy;

  logic unused_flags;
  assign unused_flags = ^{alu_full, mem_full};
`else
  assign oBUSY = '0;

  logic unused_flags;
  assign unused_flags = ^{alu_full, mem_full, alu_entries, mem_entries, alu_vld, mem_vld};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for reset and single/dual
// writes, then hand-written sequences for starvation, back-pressure and
// mid-operation reset. Busy expectations follow WB_BUSY_EN.
module tb_wb_stage;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage #(.DEPTH(2), .STARVE_MAX(3)) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iALU_VALID (bus.iALU_VALID),
    .iALU_REG   (bus.iALU_REG),
    .iALU_DATA  (bus.iALU_DATA),
    .oALU_READY (bus.oALU_READY),
    .iMEM_VALID (bus.iMEM_VALID),
    .iMEM_REG   (bus.iMEM_REG),
    .iMEM_DATA  (bus.iMEM_DATA),
    .oMEM_READY (bus.oMEM_READY),
    .oWR_EN     (bus.oWR_EN),
    .oWRREG     (bus.oWRREG),
    .oDATA      (bus.oDATA),
    .oBUSY      (bus.oBUSY)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [2:0]  ar;
    logic [11:0] ad;
    logic        mv;
    logic [2:0]  mr;
    logic [11:0] md;
    logic        wr;
    logic [2:0]  wreg;
    logic [11:0] wd;
    logic        ardy;
    logic        mrdy;
    logic [7:0]  busy;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [7:0] eb(input logic [7:0] b);
`ifdef WB_BUSY_EN
    return b;
`else
    return 8'h00 & b;
`endif
  endfunction

  function automatic vec_t mk(input logic r, input logic av, input logic [2:0] ar,
                              input logic [11:0] ad, input logic mv, input logic [2:0] mr,
                              input logic [11:0] md, input logic wr, input logic [2:0] wreg,
                              input logic [11:0] wd, input logic ardy, input logic mrdy,
                              input logic [7:0] busy);
    vec_t v;
    v.rst = r;  v.av = av;  v.ar = ar;  v.ad = ad;
    v.mv = mv;  v.mr = mr;  v.md = md;
    v.wr = wr;  v.wreg = wreg;  v.wd = wd;
    v.ardy = ardy;  v.mrdy = mrdy;  v.busy = eb(busy);
    return v;
  endfunction

  task automatic drive(input logic av, input logic [2:0] ar, input logic [11:0] ad,
                       input logic mv, input logic [2:0] mr, input logic [11:0] md);
    bus.iALU_VALID = av;
    bus.iALU_REG   = ar;
    bus.iALU_DATA  = ad;
    bus.iMEM_VALID = mv;
    bus.iMEM_REG   = mr;
    bus.iMEM_DATA  = md;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] wport();
    return {bus.oWR_EN, bus.oWRREG, bus.oDATA};
  endfunction

  vec_t        tbl [14];
  logic [15:0] sexp [7];
  logic [15:0] bexp [10];
  logic        brdy [10];
  int          bacc [10];

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000);

    //           rst   av    ar    ad        mv    mr    md        wr    wreg  wd        ardy  mrdy  busy
    tbl[0]  = mk(1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0, 1'b0, 8'h00);
    tbl[1]  = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b1, 1'b1, 8'h00);
    tbl[2]  = mk(1'b0, 1'b1, 3'd3, 12'hABC, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b1, 1'b1, 8'h08);
    tbl[3]  = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b1, 3'd3, 12'hABC, 1'b1, 1'b1, 8'h08);
    tbl[4]  = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0, 3'd3, 12'hABC, 1'b1, 1'b1, 8'h00);
    tbl[5]  = mk(1'b0, 1'b1, 3'd5, 12'h111, 1'b1, 3'd5, 12'h222, 1'b0, 3'd3, 12'hABC, 1'b1, 1'b1, 8'h20);
    tbl[6]  = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b1, 3'd5, 12'h222, 1'b1, 1'b1, 8'h20);
    tbl[7]  = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b1, 3'd5, 12'h111, 1'b1, 1'b1, 8'h20);
    tbl[8]  = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0, 3'd5, 12'h111, 1'b1, 1'b1, 8'h00);
    tbl[9]  = mk(1'b0, 1'b1, 3'd1, 12'h001, 1'b1, 3'd6, 12'h0FE, 1'b0, 3'd5, 12'h111, 1'b1, 1'b1, 8'h42);
    tbl[10] = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b1, 3'd6, 12'h0FE, 1'b1, 1'b1, 8'h42);
    tbl[11] = mk(1'b0, 1'b1, 3'd2, 12'h333, 1'b0, 3'd0, 12'h000, 1'b1, 3'd1, 12'h001, 1'b1, 1'b1, 8'h06);
    tbl[12] = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b1, 3'd2, 12'h333, 1'b1, 1'b1, 8'h04);
    tbl[13] = mk(1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0, 3'd2, 12'h333, 1'b1, 1'b1, 8'h00);

    // Starvation: write order MEM x3, ALU, MEM x3
    sexp = '{ {1'b1, 3'd7, 12'h700}, {1'b1, 3'd7, 12'h701}, {1'b1, 3'd7, 12'h702},
              {1'b1, 3'd4, 12'h444}, {1'b1, 3'd7, 12'h703}, {1'b1, 3'd7, 12'h704},
              {1'b1, 3'd7, 12'h705} };

    // Back-pressure: write port, ALU ready and ALU accept count after each edge
    bexp = '{ {1'b0, 3'd0, 12'h000}, {1'b1, 3'd0, 12'h800}, {1'b1, 3'd0, 12'h801},
              {1'b1, 3'd0, 12'h802}, {1'b1, 3'd2, 12'h900}, {1'b1, 3'd0, 12'h803},
              {1'b1, 3'd0, 12'h804}, {1'b1, 3'd2, 12'h901}, {1'b1, 3'd2, 12'h902},
              {1'b0, 3'd0, 12'h000} };
    brdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bacc = '{1, 2, 2, 2, 2, 3, 3, 3, 3, 3};

    #1;
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md);
      tick();
      chk($sformatf("table%0d", i),
          {6'b0, bus.oWR_EN, bus.oWRREG, bus.oDATA, bus.oALU_READY, bus.oMEM_READY, bus.oBUSY},
          {6'b0, tbl[i].wr, tbl[i].wreg, tbl[i].wd, tbl[i].ardy, tbl[i].mrdy, tbl[i].busy});
    end
    drive(1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000);

    // Starvation: one ALU entry waiting while MEM streams six entries
    begin
      int  macc;
      logic mfire;
      macc = 0;
      for (int c = 0; c < 8; c++) begin
        drive(c == 0, 3'd4, 12'h444, macc < 6, 3'd7, 12'h700 + 12'(macc));
        mfire = bus.iMEM_VALID && bus.oMEM_READY;
        tick();
        if (mfire) macc++;
        if (c == 0) chk("starve_first_idle", {31'b0, bus.oWR_EN}, 32'd0);
        else        chk($sformatf("starve_w%0d", c), {16'b0, wport()}, {16'b0, sexp[c-1]});
        if (c == 4) chk("starve_mem_full", {31'b0, bus.oMEM_READY}, 32'd0);
      end
      chk("starve_mem_accepts", macc, 32'd6);
      drive(1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000);
      tick();
      chk("starve_drained", {31'b0, bus.oWR_EN}, 32'd0);
    end

    // Back-pressure: three ALU pushes against a MEM stream with DEPTH=2
    begin
      int   aacc, macc;
      logic afire, mfire;
      aacc = 0;
      macc = 0;
      for (int c = 0; c < 10; c++) begin
        drive(aacc < 3, 3'd2, 12'h900 + 12'(aacc), c <= 4, 3'd0, 12'h800 + 12'(macc));
        afire = bus.iALU_VALID && bus.oALU_READY;
        mfire = bus.iMEM_VALID && bus.oMEM_READY;
        tick();
        if (afire) aacc++;
        if (mfire) macc++;
        chk($sformatf("bp_ready%0d", c), {31'b0, bus.oALU_READY}, {31'b0, brdy[c]});
        chk($sformatf("bp_acc%0d", c), aacc, bacc[c]);
        if (bexp[c][15]) chk($sformatf("bp_w%0d", c), {16'b0, wport()}, {16'b0, bexp[c]});
        else             chk($sformatf("bp_w%0d", c), {31'b0, bus.oWR_EN}, 32'd0);
      end
      drive(1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000);
    end

    // Reset with two entries queued: nothing may be written afterwards
    drive(1'b1, 3'd1, 12'hAAA, 1'b1, 3'd2, 12'hBBB);
    tick();
    chk("rst_queued", {23'b0, bus.oWR_EN, bus.oBUSY}, {23'b0, 1'b0, eb(8'h06)});
    drive(1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000);
    rst = 1'b1;
    tick();
    chk("rst_state",
        {6'b0, bus.oWR_EN, bus.oWRREG, bus.oDATA, bus.oALU_READY, bus.oMEM_READY, bus.oBUSY},
        32'd0);
    rst = 1'b0;
    tick();
    chk("rst_release", {21'b0, bus.oWR_EN, bus.oALU_READY, bus.oMEM_READY, bus.oBUSY},
        {21'b0, 1'b0, 1'b1, 1'b1, 8'h00});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_quiet%0d", k), {23'b0, bus.oWR_EN, bus.oBUSY}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
